mbist_fail_log: RTL and testbench

- Diagnostic stage directly downstream of the per-memory interface's compare logic.
- Records the address and the expected-vs-actual XOR of each failing compare during an MBIST run.
- After the run, entries are unloaded one at a time through a serial capture/shift register that hooks into the TDR chain beside pmbist_top.
- Runs on the post-mux test clock (clk_sel already resolved upstream), so the block sees a single clock.

---
 rtl/mbist_fail_log_if.sv | 27 ++
 rtl/mbist_fail_log.sv | 73 +++++++
 tb/tb_mbist_fail_log.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mbist_fail_log_if.sv
// mbist_fail_log_if: compare-side inputs and TDR-side capture/shift signals of the MBIST fail log.
interface mbist_fail_log_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7,
  parameter int CNT_W  = 8
);
  logic              mbist_run;
  logic              cmp_valid;
  logic              cmp_fail;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_diff;
  logic              capture_en;
  logic              shift_en;
  logic              si;
  logic              so;
  logic [CNT_W-1:0]  fail_count;
  logic              overflow;
  logic              log_empty;
  modport master (
    output mbist_run, cmp_valid, cmp_fail, cmp_addr, cmp_diff, capture_en, shift_en, si,
    input  so, fail_count, overflow, log_empty
  );
  modport slave (
    input  mbist_run, cmp_valid, cmp_fail, cmp_addr, cmp_diff, capture_en, shift_en, si,
    output so, fail_count, overflow, log_empty
  );
endinterface

// File: rtl/mbist_fail_log.sv
// mbist_fail_log: logs failing MBIST compares in a small FIFO and unloads them through a TDR capture/shift register.
module mbist_fail_log #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input logic             fclk,
  input logic             rst,
  mbist_fail_log_if.slave bus
);
  localparam int SR_W = 2 + CNT_W + ADDR_W + DATA_W;
  localparam int E_W  = ADDR_W + DATA_W;
  localparam int P_W  = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOG, DONE} state_t;
  state_t           state_q, state_d;
  logic             run_q;
  logic [E_W-1:0]   mem_q [DEPTH];
  logic [E_W-1:0]   mem_d [DEPTH];
  logic [P_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [P_W:0]     occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             start, log_fail, full, wr, cap, pop;
  always_comb begin
    start    = bus.mbist_run & ~run_q & (state_q != LOG);
    log_fail = (state_q == LOG) & bus.cmp_valid & bus.cmp_fail;
    full     = occ_q == (P_W+1)'(DEPTH);
    wr       = log_fail & ~full;
    cap      = bus.capture_en & (state_q != LOG);
    pop      = cap & (occ_q != '0);
    state_d  = start ? LOG : (state_q == LOG && !bus.mbist_run) ? DONE : state_q;
    mem_d    = mem_q;
    if (wr) mem_d[wr_q] = {bus.cmp_addr, bus.cmp_diff};
    wr_d  = start ? '0 : wr_q + P_W'(wr);
    rd_d  = start ? '0 : rd_q + P_W'(pop);
    occ_d = start ? '0 : occ_q + (P_W+1)'(wr) - (P_W+1)'(pop);
    cnt_d = start ? '0 : (log_fail && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    ovf_d = ~start & (ovf_q | (log_fail & full));
    // capture outranks shift even in LOG, where the register simply holds
    sr_d  = cap ? {pop, ovf_q, cnt_q, pop ? mem_q[rd_q] : E_W'(0)}
          : (bus.capture_en || !bus.shift_en) ? sr_q
          : {bus.si, sr_q[SR_W-1:1]};
  end
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= bus.mbist_run;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sr_q    <= sr_d;
    end
  end
  assign bus.so         = sr_q[0];
  assign bus.fail_count = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.log_empty  = occ_q == '0;
endmodule

// File: tb/tb_mbist_fail_log.sv
// tb_mbist_fail_log: directed and randomized runs checked against a queue-based model of the fail log.
module tb_mbist_fail_log;
  localparam int ADDR_W = 4, DATA_W = 7, DEPTH = 4, CNT_W = 8;
  localparam int SR_W = 2 + CNT_W + ADDR_W + DATA_W;
  localparam int E_W  = ADDR_W + DATA_W;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic fclk = 1'b0;
  logic rst  = 1'b1;
  always #5 fclk = ~fclk;
  mbist_fail_log_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  mbist_fail_log #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .fclk(fclk), .rst(rst), .bus(bus)
  );
  int n_chk = 0, n_pass = 0;
  logic [E_W-1:0] q[$];
  int cnt = 0;
  logic ovf = 1'b0;
  logic [SR_W-1:0] w, ew;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge fclk);
    #1;
  endtask
  task automatic model_reset();
    q.delete();
    cnt = 0;
    ovf = 1'b0;
  endtask
  task automatic check_status(input string tag);
    check({tag, "_cnt"}, 32'(bus.fail_count), 32'(cnt));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf));
    check({tag, "_empty"}, 32'(bus.log_empty), 32'(q.size() == 0));
  endtask
  // the rising-edge cycle carries a fail strobe that must not be logged
  task automatic start_run(input string tag);
    bus.mbist_run = 1'b1;
    bus.cmp_valid = 1'b1;
    bus.cmp_fail  = 1'b1;
    bus.cmp_addr  = ADDR_W'($urandom);
    bus.cmp_diff  = DATA_W'($urandom);
    tick();
    bus.cmp_valid = 1'b0;
    bus.cmp_fail  = 1'b0;
    model_reset();
    check_status(tag);
  endtask
  task automatic strobe(input bit f, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.cmp_valid = 1'b1;
    bus.cmp_fail  = f;
    bus.cmp_addr  = a;
    bus.cmp_diff  = d;
    tick();
    bus.cmp_valid = 1'b0;
    bus.cmp_fail  = 1'b0;
    if (f) begin
      cnt = (cnt < CMAX) ? cnt + 1 : cnt;
      if (q.size() < DEPTH) q.push_back({a, d});
      else ovf = 1'b1;
    end
  endtask
  task automatic end_run(input string tag);
    bus.mbist_run = 1'b0;
    tick();
    check_status(tag);
  endtask
  task automatic shift_out(output logic [SR_W-1:0] r);
    r[0] = bus.so;
    for (int i = 1; i < SR_W; i++) begin
      bus.shift_en = 1'b1;
      bus.si = 1'($urandom);
      tick();
      r[i] = bus.so;
    end
    bus.shift_en = 1'b0;
  endtask
  function automatic logic [SR_W-1:0] expect_capture();
    if (q.size() != 0) return {1'b1, ovf, CNT_W'(cnt), q.pop_front()};
    return {1'b0, ovf, CNT_W'(cnt), E_W'(0)};
  endfunction
  task automatic capture();
    bus.capture_en = 1'b1;
    bus.shift_en = 1'($urandom);
    tick();
    bus.capture_en = 1'b0;
    bus.shift_en = 1'b0;
  endtask
  task automatic unload(input string tag);
    logic [SR_W-1:0] r;
    capture();
    shift_out(r);
    check(tag, 32'(r), 32'(expect_capture()));
  endtask
  initial begin
    bus.mbist_run = 1'b0; bus.cmp_valid = 1'b0; bus.cmp_fail = 1'b0;
    bus.cmp_addr = '0; bus.cmp_diff = '0;
    bus.capture_en = 1'b0; bus.shift_en = 1'b0; bus.si = 1'b0;
    tick();
    tick();
    check_status("reset");
    check("reset_so", 32'(bus.so), 32'd0);
    rst = 1'b0;
    bus.cmp_valid = 1'b1; bus.cmp_fail = 1'b1;
    tick();
    bus.cmp_valid = 1'b0; bus.cmp_fail = 1'b0;
    check_status("idle_ignore");
    unload("t1_empty_capture");
    start_run("t2_start");
    strobe(1, 4'd3, 7'h01);
    strobe(0, 4'd1, 7'h11);
    strobe(0, 4'd2, 7'h22);
    strobe(1, 4'd9, 7'h40);
    strobe(0, 4'd4, 7'h33);
    strobe(0, 4'd5, 7'h44);
    strobe(0, 4'd6, 7'h55);
    strobe(1, 4'd15, 7'h7F);
    end_run("t2_end");
    for (int i = 0; i < 4; i++) unload($sformatf("t2_unload%0d", i));
    start_run("t3_start");
    for (int i = 0; i < 6; i++) strobe(1, ADDR_W'(i + 1), DATA_W'($urandom));
    end_run("t3_end");
    for (int i = 0; i < 5; i++) unload($sformatf("t3_unload%0d", i));
    start_run("t4_start");
    for (int i = 0; i < 300; i++) strobe(1, ADDR_W'($urandom), DATA_W'($urandom));
    end_run("t4_end");
    capture();
    ew = expect_capture();
    start_run("t5_start");
    bus.capture_en = 1'b1;
    strobe(1, 4'd7, 7'h5A);
    bus.capture_en = 1'b0;
    for (int i = 0; i < 4; i++) strobe(1, ADDR_W'($urandom), DATA_W'($urandom));
    end_run("t5_end");
    shift_out(w);
    check("t5_sr_hold", 32'(w), 32'(ew));
    unload("t5_unload0");
    unload("t5_unload1");
    start_run("t5_restart");
    end_run("t5_restart_end");
    for (int r = 0; r < 8; r++) begin
      start_run($sformatf("rnd%0d_start", r));
      for (int i = 0; i < int'($urandom_range(0, 12)); i++)
        strobe(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      end_run($sformatf("rnd%0d_end", r));
      for (int i = 0; i <= DEPTH; i++) unload($sformatf("rnd%0d_unload%0d", r, i));
    end
    start_run("t6_start");
    strobe(1, 4'd2, 7'h3C);
    strobe(1, 4'd8, 7'h41);
    end_run("t6_end");
    capture();
    for (int i = 0; i < 3; i++) begin
      bus.shift_en = 1'b1;
      bus.si = 1'b1;
      tick();
    end
    bus.shift_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_status("t6_rst_shift");
    check("t6_rst_shift_so", 32'(bus.so), 32'd0);
    shift_out(w);
    check("t6_rst_sr_zero", 32'(w), 32'd0);
    start_run("t6_run2");
    strobe(1, 4'd1, 7'h01);
    strobe(1, 4'd2, 7'h02);
    bus.cmp_valid = 1'b1; bus.cmp_fail = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mbist_run = 1'b0;
    model_reset();
    check_status("t6_rst_run");
    tick();
    bus.cmp_valid = 1'b0; bus.cmp_fail = 1'b0;
    check_status("t6_post_idle");
    unload("t6_idle_capture");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
